// File: rtl/pipe_skid_register.sv
`default_nettype none
// ============================================================================
// Module   : pipe_skid_register
// Purpose  : Generic pipeline stage register with a valid/ready handshake and
//            a 2-entry skid buffer (main + skid). ready_o comes straight from
//            a flop, so there is no combinational ready path between stages.
//            Flush either empties the stage or leaves a single NOP beat whose
//            selected fields (KEEP_MASK) are taken from data_i.
// Ports    : clk      - clock, rising edge
//            reset_n  - synchronous active-low reset
//            valid_i  - upstream beat valid
//            ready_o  - upstream may transfer (registered)
//            data_i   - upstream payload
//            valid_o  - downstream beat valid
//            ready_i  - downstream accepts (low = stall)
//            data_o   - downstream payload (main register)
//            flush_i  - flush request
//            count_o  - occupancy 0..2 (state encoding)
//            drop_o   - pulse: previous-cycle flush discarded a valid beat
// Revision : 1.0 - initial release
// ============================================================================
module pipe_skid_register #(
    parameter int                 DATA_W     = 65,
    parameter bit                 FLUSH_MODE = 1'b1,
    parameter logic [DATA_W-1:0]  FLUSH_DATA = (65'h13 << 33),
    parameter logic [DATA_W-1:0]  KEEP_MASK  = 65'h1_FFFF_FFFE
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    input  logic              flush_i,
    output logic [1:0]        count_o,
    output logic              drop_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_main_data;
    logic [DATA_W-1:0]   r_skid_data;
    logic                r_ready;
    logic                r_drop;

    logic                w_main_valid;
    logic                w_skid_valid;
    logic                w_up;
    logic                w_dn;
    logic [DATA_W-1:0]   w_flush_data;

    assign w_main_valid = (r_state != EMPTY);
    assign w_skid_valid = (r_state == FULL);
    assign w_up         = valid_i & r_ready;
    assign w_dn         = w_main_valid & ready_i;

    // NOP payload: keep selected fields (e.g. PC) from the flush-cycle input,
    // independent of valid_i.
    assign w_flush_data = (data_i & KEEP_MASK) | (FLUSH_DATA & ~KEEP_MASK);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= EMPTY;
            r_main_data <= '0;
            r_skid_data <= '0;
            r_ready     <= 1'b1;
            r_drop      <= 1'b0;
        end else if (flush_i) begin
            // A beat delivered downstream this cycle is not a drop; anything
            // else still held (or just accepted) is.
            r_drop      <= (w_main_valid & ~w_dn) | w_skid_valid | w_up;
            r_main_data <= w_flush_data;
            r_ready     <= 1'b1;
            r_state     <= FLUSH_MODE ? ONE : EMPTY;
        end else begin
            r_drop <= 1'b0;
            unique case (r_state)
                EMPTY: begin
                    if (w_up) begin
                        r_main_data <= data_i;
                        r_state     <= ONE;
                    end
                end
                ONE: begin
                    if (w_up && w_dn) begin
                        r_main_data <= data_i;
                    end else if (w_up) begin
                        // Downstream stalled: absorb the in-flight beat and
                        // close the upstream door from the next cycle.
                        r_skid_data <= data_i;
                        r_ready     <= 1'b0;
                        r_state     <= FULL;
                    end else if (w_dn) begin
                        r_state     <= EMPTY;
                    end
                end
                FULL: begin
                    // ready_o is low here, so no upstream beat can arrive.
                    if (w_dn) begin
                        r_main_data <= r_skid_data;
                        r_ready     <= 1'b1;
                        r_state     <= ONE;
                    end
                end
                default: begin
                    r_state <= EMPTY;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign ready_o = r_ready;
    assign valid_o = w_main_valid;
    assign data_o  = r_main_data;
    assign count_o = r_state;
    assign drop_o  = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_register.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_skid_register
// Purpose  : Directed self-checking bench. Two instances share one stimulus:
//            u_dut1 uses FLUSH_MODE=1 (NOP beat), u_dut0 uses FLUSH_MODE=0.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_skid_register;

    localparam int DW = 65;
    localparam logic [DW-1:0] C_NOP_BASE = (65'h13 << 33);

    logic          clk = 1'b0;
    logic          reset_n;
    logic          valid_i;
    logic          ready_i;
    logic          flush_i;
    logic [DW-1:0] data_i;

    logic          ready1, valid1, drop1;
    logic [DW-1:0] data1;
    logic [1:0]    count1;
    logic          ready0, valid0, drop0;
    logic [DW-1:0] data0;
    logic [1:0]    count0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_skid_register #(.FLUSH_MODE(1'b1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .ready_o(ready1),
        .data_i(data_i), .valid_o(valid1), .ready_i(ready_i), .data_o(data1),
        .flush_i(flush_i), .count_o(count1), .drop_o(drop1)
    );

    pipe_skid_register #(.FLUSH_MODE(1'b0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .ready_o(ready0),
        .data_i(data_i), .valid_o(valid0), .ready_i(ready_i), .data_o(data0),
        .flush_i(flush_i), .count_o(count0), .drop_o(drop0)
    );

    // Advance one clock edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; valid_i = 1'b1; ready_i = 1'b0; flush_i = 1'b0; data_i = 65'h55;
        step(); step();
        checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid1); end
        checks++; if (ready1 !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready1); end
        checks++; if (count1 !== 2'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count1); end
        checks++; if (data1 !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", data1); end
        checks++; if (drop1 !== 1'b0) begin errors++; $display("FAIL reset_drop got=%b exp=0", drop1); end
        reset_n = 1'b1; valid_i = 1'b0;
        step();
        checks++; if (count1 !== 2'd0) begin errors++; $display("FAIL reset_nostore got=%0d exp=0", count1); end
    endtask

    task automatic test_streaming();
        ready_i = 1'b1; valid_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            data_i = DW'(i);
            step();
            checks++; if (data1 !== DW'(i)) begin errors++; $display("FAIL stream_data got=%h exp=%h", data1, DW'(i)); end
            checks++; if (valid1 !== 1'b1 || count1 !== 2'd1 || ready1 !== 1'b1)
                begin errors++; $display("FAIL stream_ctl got v=%b c=%0d r=%b exp v=1 c=1 r=1", valid1, count1, ready1); end
            checks++; if (data0 !== DW'(i)) begin errors++; $display("FAIL stream_data_m0 got=%h exp=%h", data0, DW'(i)); end
        end
        valid_i = 1'b0;
        step();
        checks++; if (valid1 !== 1'b0 || count1 !== 2'd0) begin errors++; $display("FAIL stream_drain got v=%b c=%0d exp v=0 c=0", valid1, count1); end
    endtask

    task automatic test_stall_skid();
        valid_i = 1'b1; ready_i = 1'b1; data_i = 65'hA;
        step();
        checks++; if (data1 !== 65'hA || count1 !== 2'd1) begin errors++; $display("FAIL skid_load got d=%h c=%0d exp d=a c=1", data1, count1); end
        ready_i = 1'b0; data_i = 65'hB;
        step();
        checks++; if (count1 !== 2'd2) begin errors++; $display("FAIL skid_count got=%0d exp=2", count1); end
        checks++; if (ready1 !== 1'b0) begin errors++; $display("FAIL skid_ready got=%b exp=0", ready1); end
        checks++; if (data1 !== 65'hA) begin errors++; $display("FAIL skid_hold got=%h exp=a", data1); end
        valid_i = 1'b0; ready_i = 1'b1;
        step();
        checks++; if (data1 !== 65'hB || valid1 !== 1'b1) begin errors++; $display("FAIL skid_release got d=%h v=%b exp d=b v=1", data1, valid1); end
        checks++; if (ready1 !== 1'b1 || count1 !== 2'd1) begin errors++; $display("FAIL skid_reopen got r=%b c=%0d exp r=1 c=1", ready1, count1); end
        step();
        checks++; if (count1 !== 2'd0) begin errors++; $display("FAIL skid_empty got=%0d exp=0", count1); end
    endtask

    task automatic test_flush_full();
        logic [DW-1:0] exp_nop;
        valid_i = 1'b1; ready_i = 1'b1; data_i = 65'hA;
        step();
        ready_i = 1'b0; data_i = 65'hB;
        step();
        // instr field garbage, pc = 0x100, br_pred = 1: only pc survives.
        flush_i = 1'b1; valid_i = 1'b0; data_i = {32'hDEADBEEF, 32'h100, 1'b1};
        exp_nop = {32'h00000013, 32'h100, 1'b0};
        step();
        checks++; if (valid1 !== 1'b1 || data1 !== exp_nop) begin errors++; $display("FAIL flushfull_nop got v=%b d=%h exp v=1 d=%h", valid1, data1, exp_nop); end
        checks++; if (count1 !== 2'd1 || ready1 !== 1'b1 || drop1 !== 1'b1)
            begin errors++; $display("FAIL flushfull_ctl got c=%0d r=%b dr=%b exp c=1 r=1 dr=1", count1, ready1, drop1); end
        checks++; if (valid0 !== 1'b0 || count0 !== 2'd0 || drop0 !== 1'b1 || data0 !== exp_nop)
            begin errors++; $display("FAIL flushfull_m0 got v=%b c=%0d dr=%b d=%h exp v=0 c=0 dr=1 d=%h", valid0, count0, drop0, data0, exp_nop); end
        flush_i = 1'b0;
        step();
        checks++; if (drop1 !== 1'b0 || valid1 !== 1'b1 || data1 !== exp_nop)
            begin errors++; $display("FAIL flushfull_hold got dr=%b v=%b d=%h exp dr=0 v=1 d=%h", drop1, valid1, data1, exp_nop); end
        ready_i = 1'b1;
        step();
        checks++; if (count1 !== 2'd0) begin errors++; $display("FAIL flushfull_drain got=%0d exp=0", count1); end
    endtask

    task automatic test_flush_dn();
        valid_i = 1'b1; ready_i = 1'b1; data_i = 65'hA;
        step();
        // A is delivered this cycle while C is accepted and then discarded.
        flush_i = 1'b1; data_i = 65'hC;
        step();
        checks++; if (valid0 !== 1'b0 || count0 !== 2'd0) begin errors++; $display("FAIL flushdn_m0 got v=%b c=%0d exp v=0 c=0", valid0, count0); end
        checks++; if (drop0 !== 1'b1) begin errors++; $display("FAIL flushdn_drop_m0 got=%b exp=1", drop0); end
        checks++; if (valid1 !== 1'b1 || data1 !== (C_NOP_BASE | 65'hC) || drop1 !== 1'b1)
            begin errors++; $display("FAIL flushdn_m1 got v=%b d=%h dr=%b exp v=1 d=%h dr=1", valid1, data1, drop1, C_NOP_BASE | 65'hC); end
        flush_i = 1'b0; valid_i = 1'b0;
        step();
        checks++; if (count1 !== 2'd0 || count0 !== 2'd0 || drop0 !== 1'b0)
            begin errors++; $display("FAIL flushdn_after got c1=%0d c0=%0d dr0=%b exp 0 0 0", count1, count0, drop0); end
    endtask

    task automatic test_flush_empty();
        valid_i = 1'b0; ready_i = 1'b0; flush_i = 1'b1; data_i = 65'h200;
        step();
        checks++; if (drop1 !== 1'b0 || drop0 !== 1'b0) begin errors++; $display("FAIL flushempty_drop got d1=%b d0=%b exp 0 0", drop1, drop0); end
        checks++; if (valid1 !== 1'b1 || count1 !== 2'd1 || data1 !== (C_NOP_BASE | 65'h200))
            begin errors++; $display("FAIL flushempty_m1 got v=%b c=%0d d=%h exp v=1 c=1 d=%h", valid1, count1, data1, C_NOP_BASE | 65'h200); end
        checks++; if (valid0 !== 1'b0 || count0 !== 2'd0) begin errors++; $display("FAIL flushempty_m0 got v=%b c=%0d exp v=0 c=0", valid0, count0); end
        // Back-to-back: the stalled NOP in mode 1 is itself discarded.
        step();
        checks++; if (drop1 !== 1'b1 || drop0 !== 1'b0) begin errors++; $display("FAIL flushb2b_drop got d1=%b d0=%b exp 1 0", drop1, drop0); end
        flush_i = 1'b0; ready_i = 1'b1;
        step();
        checks++; if (count1 !== 2'd0 || drop1 !== 1'b0) begin errors++; $display("FAIL flushempty_drain got c=%0d dr=%b exp 0 0", count1, drop1); end
    endtask

    task automatic test_reset_mid();
        valid_i = 1'b1; ready_i = 1'b1; data_i = 65'hA;
        step();
        ready_i = 1'b0; data_i = 65'hB;
        step();
        checks++; if (count1 !== 2'd2) begin errors++; $display("FAIL rstmid_setup got=%0d exp=2", count1); end
        reset_n = 1'b0; data_i = 65'h77;
        step();
        checks++; if (valid1 !== 1'b0 || ready1 !== 1'b1 || count1 !== 2'd0 || data1 !== '0 || drop1 !== 1'b0)
            begin errors++; $display("FAIL rstmid_state got v=%b r=%b c=%0d d=%h dr=%b exp 0 1 0 0 0", valid1, ready1, count1, data1, drop1); end
        reset_n = 1'b1; valid_i = 1'b0;
        step();
        checks++; if (count1 !== 2'd0 || valid1 !== 1'b0 || drop1 !== 1'b0)
            begin errors++; $display("FAIL rstmid_nostore got c=%0d v=%b dr=%b exp 0 0 0", count1, valid1, drop1); end
    endtask

    initial begin
        reset_n = 1'b0; valid_i = 1'b0; ready_i = 1'b0; flush_i = 1'b0; data_i = '0;
        #2;
        test_reset();
        test_streaming();
        test_stall_skid();
        test_flush_full();
        test_flush_dn();
        test_flush_empty();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
